ex_operand_stage: RTL and testbench

Pipeline stage directly upstream of the ALU: registers decoded operands and control from decode (ID/EX boundary), resolves data hazards by forwarding from MEM and WB, and drives the ALU's `SrcA`, `SrcB` and `Operation` inputs. It also detects load-use hazards and inserts a bubble. It is the only path by which the ALU receives operands in the pipelined core.

---
 rtl/riscv_ex_pkg.sv | 32 +++
 rtl/forward_unit.sv | 33 +++
 rtl/ex_operand_stage.sv | 157 +++++++++++++++
 tb/tb_ex_operand_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ex_pkg.sv
// Shared definitions for the EX operand stage: ALU opcodes, registered control
// bundle and the bubble value loaded on flush, hazard or an empty decode slot.
package riscv_ex_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SRA = 4'b0111;
    localparam logic [3:0] ALU_EQ  = 4'b1000;
    localparam logic [3:0] ALU_XOR = 4'b1001;
    localparam logic [3:0] ALU_NE  = 4'b1010;
    localparam logic [3:0] ALU_SLT = 4'b1100;
    localparam logic [3:0] ALU_GE  = 4'b1101;
    localparam logic [3:0] ALU_LT  = 4'b1110;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic branch;
        logic a_sel_pc;
        logic b_sel_imm;
    } ex_ctrl_t;

    localparam ex_ctrl_t EX_BUBBLE = '0;

endpackage

// File: rtl/forward_unit.sv
// Combinational operand selector: MEM result beats WB result beats the
// register-file value captured at ID/EX; register x0 is never forwarded.
module forward_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] idx,
    input  logic [DATA_WIDTH-1:0]     rf_data,
    input  logic                      mem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0]     mem_result,
    input  logic                      wb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]     wb_result,
    output logic [DATA_WIDTH-1:0]     fwd_data
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_reg_write && (mem_rd != '0) && (mem_rd == idx);
    assign wb_hit  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == idx);

    always_comb begin
        fwd_data = rf_data;
        if (mem_hit) begin
            fwd_data = mem_result;
        end else if (wb_hit) begin
            fwd_data = wb_result;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB forwarding into the ALU operands and
// load-use hazard detection that inserts a single bubble.
module ex_operand_stage
    import riscv_ex_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_LENGTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [DATA_WIDTH-1:0]     id_pc,
    input  logic [DATA_WIDTH-1:0]     id_rs1_data,
    input  logic [DATA_WIDTH-1:0]     id_rs2_data,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic [OPCODE_LENGTH-1:0]  id_alu_op,
    input  logic                      id_a_sel_pc,
    input  logic                      id_b_sel_imm,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      id_mem_write,
    input  logic                      id_mem_to_reg,
    input  logic                      id_branch,
    input  logic                      mem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0]     mem_result,
    input  logic                      wb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]     wb_result,
    output logic [DATA_WIDTH-1:0]     SrcA,
    output logic [DATA_WIDTH-1:0]     SrcB,
    output logic [OPCODE_LENGTH-1:0]  Operation,
    output logic                      ex_valid,
    output logic                      ex_reg_write,
    output logic                      ex_mem_read,
    output logic                      ex_mem_write,
    output logic                      ex_mem_to_reg,
    output logic                      ex_branch,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic [DATA_WIDTH-1:0]     ex_pc,
    output logic [DATA_WIDTH-1:0]     ex_imm,
    output logic [DATA_WIDTH-1:0]     ex_store_data,
    output logic                      hazard_stall
);

    ex_ctrl_t                  ctrl_reg;
    ex_ctrl_t                  id_ctrl;
    logic [OPCODE_LENGTH-1:0]  op_reg;
    logic [REG_ADDR_WIDTH-1:0] rs1_reg;
    logic [REG_ADDR_WIDTH-1:0] rs2_reg;
    logic [REG_ADDR_WIDTH-1:0] rd_reg;
    logic [DATA_WIDTH-1:0]     pc_reg;
    logic [DATA_WIDTH-1:0]     rs1_data_reg;
    logic [DATA_WIDTH-1:0]     rs2_data_reg;
    logic [DATA_WIDTH-1:0]     imm_reg;

    logic [REG_ADDR_WIDTH-1:0] src_idx [2];
    logic [DATA_WIDTH-1:0]     src_rf  [2];
    logic [DATA_WIDTH-1:0]     src_fwd [2];

    always_comb begin
        id_ctrl            = EX_BUBBLE;
        id_ctrl.valid      = id_valid;
        id_ctrl.reg_write  = id_reg_write;
        id_ctrl.mem_read   = id_mem_read;
        id_ctrl.mem_write  = id_mem_write;
        id_ctrl.mem_to_reg = id_mem_to_reg;
        id_ctrl.branch     = id_branch;
        id_ctrl.a_sel_pc   = id_a_sel_pc;
        id_ctrl.b_sel_imm  = id_b_sel_imm;
    end

    // A load in EX cannot forward to the instruction in decode until it reaches MEM.
    assign hazard_stall = !flush && ctrl_reg.valid && ctrl_reg.mem_read
                          && (rd_reg != '0) && id_valid
                          && ((id_rs1 == rd_reg) || (id_rs2 == rd_reg));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_reg     <= EX_BUBBLE;
            op_reg       <= '0;
            rs1_reg      <= '0;
            rs2_reg      <= '0;
            rd_reg       <= '0;
            pc_reg       <= '0;
            rs1_data_reg <= '0;
            rs2_data_reg <= '0;
            imm_reg      <= '0;
        end else if (flush || (!stall && (hazard_stall || !id_valid))) begin
            ctrl_reg     <= EX_BUBBLE;
            op_reg       <= '0;
            rs1_reg      <= '0;
            rs2_reg      <= '0;
            rd_reg       <= '0;
            pc_reg       <= '0;
            rs1_data_reg <= '0;
            rs2_data_reg <= '0;
            imm_reg      <= '0;
        end else if (!stall) begin
            ctrl_reg     <= id_ctrl;
            op_reg       <= id_alu_op;
            rs1_reg      <= id_rs1;
            rs2_reg      <= id_rs2;
            rd_reg       <= id_rd;
            pc_reg       <= id_pc;
            rs1_data_reg <= id_rs1_data;
            rs2_data_reg <= id_rs2_data;
            imm_reg      <= id_imm;
        end
    end

    assign src_idx[0] = rs1_reg;
    assign src_idx[1] = rs2_reg;
    assign src_rf[0]  = rs1_data_reg;
    assign src_rf[1]  = rs2_data_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            forward_unit #(
                .DATA_WIDTH    (DATA_WIDTH),
                .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
            ) u_forward_unit (
                .idx          (src_idx[gi]),
                .rf_data      (src_rf[gi]),
                .mem_reg_write(mem_reg_write),
                .mem_rd       (mem_rd),
                .mem_result   (mem_result),
                .wb_reg_write (wb_reg_write),
                .wb_rd        (wb_rd),
                .wb_result    (wb_result),
                .fwd_data     (src_fwd[gi])
            );
        end
    endgenerate

    assign SrcA          = ctrl_reg.a_sel_pc  ? pc_reg  : src_fwd[0];
    assign SrcB          = ctrl_reg.b_sel_imm ? imm_reg : src_fwd[1];
    assign ex_store_data = src_fwd[1];
    assign Operation     = op_reg;

    assign ex_valid      = ctrl_reg.valid;
    assign ex_reg_write  = ctrl_reg.reg_write;
    assign ex_mem_read   = ctrl_reg.mem_read;
    assign ex_mem_write  = ctrl_reg.mem_write;
    assign ex_mem_to_reg = ctrl_reg.mem_to_reg;
    assign ex_branch     = ctrl_reg.branch;
    assign ex_rd         = rd_reg;
    assign ex_pc         = pc_reg;
    assign ex_imm        = imm_reg;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed scenarios followed by random traffic,
// all compared against a slot-level model of the ID/EX register.
module tb_ex_operand_stage;
    import riscv_ex_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_op;
    logic        id_a_sel_pc, id_b_sel_imm, id_reg_write, id_mem_read;
    logic        id_mem_write, id_mem_to_reg, id_branch;
    logic        mem_reg_write, wb_reg_write;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_result, wb_result;
    logic [31:0] SrcA, SrcB, ex_pc, ex_imm, ex_store_data;
    logic [3:0]  Operation;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic        ex_mem_to_reg, ex_branch, hazard_stall;
    logic [4:0]  ex_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_a_sel_pc(id_a_sel_pc), .id_b_sel_imm(id_b_sel_imm), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .id_branch(id_branch), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .mem_result(mem_result), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_result(wb_result), .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
        .ex_rd(ex_rd), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_store_data(ex_store_data),
        .hazard_stall(hazard_stall)
    );

    // Model of the instruction sitting in EX.
    typedef struct packed {
        logic        v, rw, mr, mw, m2r, br, asel, bsel;
        logic [3:0]  op;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] pc, d1, d2, imm;
    } slot_t;

    slot_t m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf);
        if (idx != 0 && mem_reg_write && mem_rd == idx) return mem_result;
        if (idx != 0 && wb_reg_write && wb_rd == idx) return wb_result;
        return rf;
    endfunction

    function automatic logic exp_hazard();
        return !flush && m.v && m.mr && m.rd != 0 && id_valid
               && (id_rs1 == m.rd || id_rs2 == m.rd);
    endfunction

    task automatic check_all(input string ph);
        logic [31:0] f1, f2;
        f1 = fwd(m.rs1, m.d1);
        f2 = fwd(m.rs2, m.d2);
        check({ph, ".SrcA"}, SrcA, m.asel ? m.pc : f1);
        check({ph, ".SrcB"}, SrcB, m.bsel ? m.imm : f2);
        check({ph, ".store"}, ex_store_data, f2);
        check({ph, ".Operation"}, {28'd0, Operation}, {28'd0, m.op});
        check({ph, ".ctrl"}, {26'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
                              ex_mem_to_reg, ex_branch},
              {26'd0, m.v, m.rw, m.mr, m.mw, m.m2r, m.br});
        check({ph, ".rd"}, {27'd0, ex_rd}, {27'd0, m.rd});
        check({ph, ".pc"}, ex_pc, m.pc);
        check({ph, ".imm"}, ex_imm, m.imm);
        check({ph, ".hazard"}, {31'd0, hazard_stall}, {31'd0, exp_hazard()});
    endtask

    // Called just after a falling edge with inputs set: check, clock, update model.
    task automatic step(input string ph);
        logic haz;
        #1;
        check_all(ph);
        haz = exp_hazard();
        @(posedge clk);
        if (reset || flush) m = '0;
        else if (stall) m = m;
        else if (haz || !id_valid) m = '0;
        else m = '{v:1'b1, rw:id_reg_write, mr:id_mem_read, mw:id_mem_write,
                   m2r:id_mem_to_reg, br:id_branch, asel:id_a_sel_pc, bsel:id_b_sel_imm,
                   op:id_alu_op, rs1:id_rs1, rs2:id_rs2, rd:id_rd, pc:id_pc,
                   d1:id_rs1_data, d2:id_rs2_data, imm:id_imm};
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        {stall, flush, id_valid, id_a_sel_pc, id_b_sel_imm, id_reg_write, id_mem_read,
         id_mem_write, id_mem_to_reg, id_branch, mem_reg_write, wb_reg_write} = '0;
        {id_pc, id_rs1_data, id_rs2_data, id_imm, mem_result, wb_result} = '0;
        {id_rs1, id_rs2, id_rd, mem_rd, wb_rd} = '0;
        id_alu_op = '0;
    endtask

    task automatic random_inputs();
        id_valid      = ($urandom_range(0, 9) < 8);
        flush         = ($urandom_range(0, 9) == 0);
        stall         = ($urandom_range(0, 9) < 2);
        id_pc         = $urandom; id_rs1_data = $urandom;
        id_rs2_data   = $urandom; id_imm = $urandom;
        id_rs1        = 5'($urandom_range(0, 7));
        id_rs2        = 5'($urandom_range(0, 7));
        id_rd         = 5'($urandom_range(0, 7));
        id_alu_op     = 4'($urandom);
        id_a_sel_pc   = ($urandom_range(0, 3) == 0);
        id_b_sel_imm  = ($urandom_range(0, 2) == 0);
        id_reg_write  = 1'($urandom);
        id_mem_read   = ($urandom_range(0, 2) == 0);
        id_mem_write  = 1'($urandom);
        id_mem_to_reg = 1'($urandom);
        id_branch     = 1'($urandom);
        mem_reg_write = 1'($urandom);
        mem_rd        = 5'($urandom_range(0, 7));
        mem_result    = $urandom;
        wb_reg_write  = 1'($urandom);
        wb_rd         = 5'($urandom_range(0, 7));
        wb_result     = $urandom;
    endtask

    task automatic load_instr(input logic [4:0] rs1, rs2, rd, input logic [31:0] d1, d2,
                              input logic [3:0] op);
        clear_inputs();
        id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_alu_op = op; id_reg_write = 1'b1;
    endtask

    initial begin
        m = '0;
        reset = 1'b1;
        random_inputs();
        @(negedge clk);
        #1;
        check_all("reset");
        check("reset.valid", {31'd0, ex_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ADD x3 = x1 + x2
        load_instr(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, ALU_ADD);
        step("add_load");
        clear_inputs();
        #1;
        check("add.SrcA", SrcA, 32'd5);
        check("add.SrcB", SrcB, 32'd7);
        check("add.op", {28'd0, Operation}, 32'h2);
        step("add_ex");

        // Forwarding priority and x0 blocking, held in EX by stall
        load_instr(5'd4, 5'd0, 5'd9, 32'h11, 32'h22, ALU_OR);
        step("fwd_load");
        stall = 1'b1;
        mem_reg_write = 1'b1; mem_rd = 5'd4; mem_result = 32'h10;
        #1 check("fwd.mem", SrcA, 32'h10);
        wb_reg_write = 1'b1; wb_rd = 5'd4; wb_result = 32'h20;
        #1 check("fwd.mem_over_wb", SrcA, 32'h10);
        mem_reg_write = 1'b0;
        #1 check("fwd.wb", SrcA, 32'h20);
        mem_reg_write = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0;
        #1 check("fwd.x0_rs2", SrcB, 32'h22);
        step("fwd_hold");
        load_instr(5'd0, 5'd0, 5'd1, 32'h33, 32'h44, ALU_AND);
        step("x0_load");
        mem_reg_write = 1'b1; mem_rd = 5'd0; mem_result = 32'hDEAD;
        #1 check("fwd.x0_rs1", SrcA, 32'h33);
        step("x0_ex");

        // Load-use hazard: LW x5 then ADD rs1=x5
        load_instr(5'd1, 5'd0, 5'd5, 32'h0, 32'h0, ALU_ADD);
        id_mem_read = 1'b1; id_mem_to_reg = 1'b1;
        step("lw_load");
        load_instr(5'd5, 5'd2, 5'd6, 32'h1, 32'h2, ALU_ADD);
        #1 check("lu.hazard", {31'd0, hazard_stall}, 32'd1);
        step("lu_detect");
        check("lu.bubble_valid", {31'd0, ex_valid}, 32'd0);
        check("lu.bubble_op", {28'd0, Operation}, 32'd0);
        mem_reg_write = 1'b1; mem_rd = 5'd5; mem_result = 32'h5A5A;
        step("lu_reissue");
        #1 check("lu.fwd", SrcA, 32'h5A5A);
        step("lu_ex");

        // Stall three cycles with changing decode, then flush
        load_instr(5'd7, 5'd6, 5'd2, 32'h77, 32'h66, ALU_XOR);
        id_pc = 32'h200;
        step("stall_load");
        for (int i = 0; i < 3; i++) begin
            random_inputs();
            stall = 1'b1; flush = 1'b0;
            step("stall");
            check("stall.pc", ex_pc, 32'h200);
        end
        clear_inputs();
        load_instr(5'd1, 5'd1, 5'd1, 32'h1, 32'h1, ALU_SUB);
        flush = 1'b1;
        step("flush");
        check("flush.valid", {31'd0, ex_valid}, 32'd0);

        // ADDI with all-ones immediate, rs2 forwarded from WB
        load_instr(5'd1, 5'd6, 5'd8, 32'h3, 32'h4, ALU_ADD);
        id_b_sel_imm = 1'b1; id_imm = 32'hFFFF_FFFF;
        step("addi_load");
        clear_inputs();
        wb_reg_write = 1'b1; wb_rd = 5'd6; wb_result = 32'hABCD;
        #1 check("addi.SrcB", SrcB, 32'hFFFF_FFFF);
        check("addi.store", ex_store_data, 32'hABCD);
        step("addi_ex");

        // AUIPC then asynchronous reset between edges
        load_instr(5'd0, 5'd0, 5'd10, 32'h0, 32'h0, ALU_ADD);
        id_a_sel_pc = 1'b1; id_b_sel_imm = 1'b1; id_pc = 32'h100; id_imm = 32'h1000;
        step("auipc_load");
        clear_inputs();
        #1 check("auipc.SrcA", SrcA, 32'h100);
        reset = 1'b1;
        #1;
        m = '0;
        check("areset.SrcA", SrcA, 32'd0);
        check_all("areset");
        @(negedge clk);
        reset = 1'b0;

        for (int n = 0; n < 400; n++) begin
            random_inputs();
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
